// File: rtl/bit_vector_fifo.sv
// Bit-serial to VEC_W-bit vector deserialiser feeding a DEPTH-entry first-word-fall-through FIFO.
// Latency: the last bit of a vector is accepted on an edge; the vector is visible on vec_data from the next cycle.
// Backpressure: only the completing bit of a vector stalls while full (bit_ready=0). A dropped valid bit sets sticky overflow.
module bit_vector_fifo #(
    parameter int VEC_W     = 8,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       flush,
    output logic [VEC_W-1:0]           vec_data,
    output logic                       vec_valid,
    input  logic                       vec_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(VEC_W)-1:0]   fill,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(VEC_W);

    // Reject unsupported parameterisations at elaboration time.
    if (VEC_W < 2) begin : g_bad_vec_w
        $error("bit_vector_fifo: VEC_W must be >= 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("bit_vector_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [VEC_W-1:0] asm_q;
    logic [VEC_W-1:0] asm_nxt;
    logic             accept;
    logic             last_bit;
    logic             complete;
    logic             pop;

    // Shift direction decides which end of the vector the first bit ends up in.
    if (MSB_FIRST) begin : g_msb_first
        assign asm_nxt = {asm_q[VEC_W-2:0], bit_in};
    end else begin : g_lsb_first
        assign asm_nxt = {bit_in, asm_q[VEC_W-1:1]};
    end

    // Status and handshakes derive from registered state only; vec_ready never reaches bit_ready.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign last_bit  = (fill == FW'(VEC_W - 1));
    assign bit_ready = !(full && last_bit);
    assign accept    = bit_valid && bit_ready;
    assign complete  = accept && last_bit;
    assign vec_valid = !empty;
    assign pop       = vec_valid && vec_ready;
    assign vec_data  = vec_valid ? mem[rd_ptr] : '0;

    // Control state: flush outranks any bit or pop presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fill     <= '0;
            asm_q    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fill     <= '0;
            asm_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                asm_q <= asm_nxt;
                fill  <= complete ? '0 : fill + FW'(1);
            end
            if (complete) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (complete && !pop) begin
                count <= count + CW'(1);
            end else if (!complete && pop) begin
                count <= count - CW'(1);
            end
            if (bit_valid && !bit_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage write: the completed vector includes the bit arriving on this edge.
    always_ff @(posedge clk) begin
        if (complete && !flush) begin
            mem[wr_ptr] <= asm_nxt;
        end
    end

endmodule

// File: tb/tb_bit_vector_fifo.sv
module tb_bit_vector_fifo;

    localparam int VEC_W     = 8;
    localparam int DEPTH     = 4;
    localparam bit MSB_FIRST = 1'b1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     bit_in;
    logic                     bit_valid;
    logic                     bit_ready;
    logic                     flush;
    logic [VEC_W-1:0]         vec_data;
    logic                     vec_valid;
    logic                     vec_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic [$clog2(VEC_W)-1:0] fill;
    logic                     overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: received bits of the partial vector, stored vectors, sticky flag.
    int               mbits[$];
    logic [VEC_W-1:0] mq[$];
    bit               movf;
    // Scoreboard consumed by the output monitor.
    logic [VEC_W-1:0] sb[$];

    bit_vector_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .flush(flush), .vec_data(vec_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .count(count),
        .full(full), .empty(empty), .fill(fill), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mready();
        return !(mq.size() == DEPTH && mbits.size() == VEC_W - 1);
    endfunction

    function automatic logic [VEC_W-1:0] build_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (MSB_FIRST) v[VEC_W-1-i] = mbits[i][0];
            else           v[i]         = mbits[i][0];
        end
        return v;
    endfunction

    task automatic model_clear();
        mbits.delete();
        mq.delete();
        sb.delete();
        movf = 1'b0;
    endtask

    task automatic check_state();
        chk("vec_valid", vec_valid, mq.size() != 0);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("fill", fill, mbits.size());
        chk("bit_ready", bit_ready, mready());
        chk("overflow", overflow, movf);
        chk("head_data", vec_data, (mq.size() != 0) ? mq[0] : '0);
    endtask

    // One clock: drive inputs, check state at negedge, advance the model across the edge.
    task automatic cycle(input bit bv, input bit bi, input bit vr, input bit fl);
        bit               rdy;
        bit               do_pop;
        bit               push;
        logic [VEC_W-1:0] nv;
        bit_valid = bv; bit_in = bi; vec_ready = vr; flush = fl;
        @(negedge clk);
        check_state();
        if (fl) begin
            model_clear();
        end else begin
            rdy    = mready();
            do_pop = (mq.size() != 0) && vr;
            push   = 1'b0;
            nv     = '0;
            if (bv && !rdy) movf = 1'b1;
            if (bv && rdy) begin
                mbits.push_back(int'(bi));
                if (mbits.size() == VEC_W) begin
                    nv   = build_vec();
                    push = 1'b1;
                    mbits.delete();
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(nv);
                sb.push_back(nv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [VEC_W-1:0] v, input int lo, input int hi, input bit vr);
        for (int i = lo; i <= hi; i++) begin
            cycle(1'b1, MSB_FIRST ? v[VEC_W-1-i] : v[i], vr, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit vr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, vr, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 4 * DEPTH + 8;
        while (mq.size() != 0 && budget > 0) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            budget--;
        end
        chk("drain_done", mq.size(), 0);
    endtask

    // Output monitor: every pop handshake must deliver the oldest outstanding vector.
    always begin
        @(negedge clk);
        if (rst_n && !flush && vec_valid && vec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no vector at %0t", vec_data, $time);
            end else begin
                chk("pop_data", vec_data, sb.pop_front());
            end
        end
    end

    initial begin
        logic [VEC_W-1:0] pat;
        int               tg;
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; vec_ready = 1'b0; flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_vec_data", vec_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_fill", fill, 0);
        chk("rst_bit_ready", bit_ready, 1);
        chk("rst_overflow", overflow, 0);
        idle(2, 1'b0);

        // Bit order
        pat = 8'b1011_0010;
        for (int i = 0; i < VEC_W; i++) cycle(1'b1, pat[VEC_W-1-i], 1'b0, 1'b0);
        chk("order_valid", vec_valid, 1);
        chk("order_data", vec_data, MSB_FIRST ? 8'hB2 : 8'h4D);
        chk("order_fill", fill, 0);
        drain();

        // Full and overflow
        send_range(8'h11, 0, VEC_W - 1, 1'b0);
        send_range(8'h22, 0, VEC_W - 1, 1'b0);
        send_range(8'h33, 0, VEC_W - 1, 1'b0);
        send_range(8'h44, 0, VEC_W - 1, 1'b0);
        chk("full_flag", full, 1);
        chk("full_count", count, DEPTH);
        send_range(8'h55, 0, VEC_W - 2, 1'b0);
        chk("full_fill7", fill, VEC_W - 1);
        chk("full_stall", bit_ready, 0);
        send_range(8'h55, VEC_W - 1, VEC_W - 1, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", vec_data, 8'h11);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop_reenable", bit_ready, 1);
        send_range(8'h55, VEC_W - 1, VEC_W - 1, 1'b0);
        drain();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push and pop
        send_range(8'h01, 0, VEC_W - 1, 1'b0);
        send_range(8'h02, 0, VEC_W - 1, 1'b0);
        send_range(8'hA5, 0, VEC_W - 2, 1'b0);
        send_range(8'hA5, VEC_W - 1, VEC_W - 1, 1'b1);
        chk("pushpop_count", count, 2);
        drain();

        // Wrap-around with a half-rate consumer
        tg = 0;
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < VEC_W; i++) begin
                pat = 8'(v);
                cycle(1'b1, MSB_FIRST ? pat[VEC_W-1-i] : pat[i], (tg % 2) == 0, 1'b0);
                tg++;
            end
        end
        drain();
        chk("wrap_ovf", overflow, 0);

        // Flush mid-operation
        for (int v = 0; v < DEPTH; v++) send_range(8'(8'hC0 + v), 0, VEC_W - 1, 1'b0);
        send_range(8'h3C, 0, VEC_W - 1, 1'b0);
        idle(2, 1'b1);
        send_range(8'h3C, VEC_W - 1, VEC_W - 1, 1'b0);
        idle(1, 1'b1);
        send_range(8'h96, 0, 2, 1'b0);
        chk("pre_flush_count", count, 2);
        chk("pre_flush_fill", fill, 3);
        chk("pre_flush_ovf", overflow, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_fill", fill, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_data", vec_data, 0);
        chk("flush_valid", vec_valid, 0);

        // Asynchronous reset mid-operation
        send_range(8'h5A, 0, VEC_W - 1, 1'b0);
        send_range(8'h69, 0, VEC_W - 1, 1'b0);
        send_range(8'hF0, 0, 2, 1'b0);
        bit_valid = 1'b0; vec_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", vec_valid, 0);
        chk("arst_data", vec_data, 0);
        chk("arst_count", count, 0);
        chk("arst_fill", fill, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ready", bit_ready, 1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1, 1'b0);

        // Randomised traffic with occasional flushes
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 149) == 0);
        end
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
